safety_mem_arbiter: RTL and testbench

SAFETY_MEM_ARBITER -- requirements
Module: safety_mem_arbiter

---
 rtl/safety_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_safety_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/safety_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one in-order memory port.
// Round-robin with grant lock, and a source-ID FIFO that routes responses.
module safety_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;
  typedef enum logic [1:0] {LOCK_NONE, LOCK_INSTR, LOCK_DATA} lock_e;

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] fifo_q, fifo_d;
  src_e       prio_q, prio_d;
  lock_e      lock_q, lock_d;
  logic       perr_q, perr_d;

  src_e sel;
  src_e head;
  logic sel_req, full, empty, hs, pop;

  always_comb begin
    full  = (cnt_q == 4'(MaxOutstanding));
    empty = (cnt_q == '0);
    case (lock_q)
      LOCK_INSTR: sel = SRC_INSTR;
      LOCK_DATA:  sel = SRC_DATA;
      default: begin
        if (instr_req_i && data_req_i) sel = prio_q;
        else if (instr_req_i)          sel = SRC_INSTR;
        else                           sel = SRC_DATA;
      end
    endcase
    sel_req   = (sel == SRC_INSTR) ? instr_req_i : data_req_i;
    mem_req_o = rst_ni && sel_req && !full;
    hs        = mem_req_o && mem_gnt_i;

    instr_gnt_o = hs && (sel == SRC_INSTR);
    data_gnt_o  = hs && (sel == SRC_DATA);

    if (sel == SRC_INSTR) begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = '0;
    end else begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end

    // A response with nothing outstanding is dropped, not routed.
    head           = src_e'(fifo_q[0]);
    pop            = rst_ni && mem_rvalid_i && !empty;
    instr_rvalid_o = pop && (head == SRC_INSTR);
    data_rvalid_o  = pop && (head == SRC_DATA);
    instr_err_o    = instr_rvalid_o && mem_err_i;
    data_err_o     = data_rvalid_o && mem_err_i;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    protocol_err_o = perr_q;
  end

  always_comb begin
    prio_d = prio_q;
    if (hs && (sel == prio_q)) prio_d = (prio_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;

    lock_d = lock_q;
    if (hs)             lock_d = LOCK_NONE;
    else if (mem_req_o) lock_d = (sel == SRC_INSTR) ? LOCK_INSTR : LOCK_DATA;

    // Head lives at bit 0; pop shifts first so a same-cycle push lands after the survivors.
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (pop) begin
      fifo_d = fifo_q >> 1;
      cnt_d  = cnt_q - 4'd1;
    end
    if (hs) begin
      fifo_d[cnt_d[2:0]] = sel;
      cnt_d              = cnt_d + 4'd1;
    end

    perr_d = perr_q || (mem_rvalid_i && empty);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      fifo_q <= '0;
      prio_q <= SRC_DATA;
      lock_q <= LOCK_NONE;
      perr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fifo_q <= fifo_d;
      prio_q <= prio_d;
      lock_q <= lock_d;
      perr_q <= perr_d;
    end
  end

endmodule

// File: tb/tb_safety_mem_arbiter.sv
// Directed bench for safety_mem_arbiter: arbitration, locking, FIFO limits,
// response routing, protocol error and reset behaviour.
module tb_safety_mem_arbiter;

  localparam logic [31:0] IADDR = 32'h0000_1000;
  localparam logic [31:0] DADDR = 32'h0000_8004;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        protocol_err_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  safety_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .protocol_err_o(protocol_err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    instr_req_i  = 1'b0; instr_addr_i = IADDR;
    data_req_i   = 1'b0; data_we_i    = 1'b0; data_be_i = 4'h3;
    data_addr_i  = DADDR; data_wdata_i = 32'hDEAD_BEEF;
    mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    tick();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req_o); end
    n_checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin
      n_fail++; $display("FAIL rst_gnt got %b want 00", {instr_gnt_o, data_gnt_o});
    end
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      n_fail++; $display("FAIL rst_rvalid got %b want 00", {instr_rvalid_o, data_rvalid_o});
    end
    tick();
    n_checks++;
    if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_perr got %b want 0", protocol_err_o); end
    rst_ni = 1'b1;
    idle();
  endtask

  task automatic test_round_robin();
    logic exp_d;
    for (int i = 0; i < 4; i++) begin
      instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
      mem_rvalid_i = (i != 0); mem_rdata_i = 32'hA000_0000 + i; mem_err_i = (i == 2);
      exp_d = (i % 2 == 0);
      #1;
      n_checks++;
      if ({instr_gnt_o, data_gnt_o} !== {!exp_d, exp_d}) begin
        n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", i, {instr_gnt_o, data_gnt_o}, {!exp_d, exp_d});
      end
      n_checks++;
      if (mem_addr_o !== (exp_d ? DADDR : IADDR)) begin
        n_fail++; $display("FAIL rr_addr[%0d] got %h want %h", i, mem_addr_o, exp_d ? DADDR : IADDR);
      end
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {i == 2, i == 1 || i == 3}) begin
        n_fail++; $display("FAIL rr_rvalid[%0d] got %b want %b", i, {instr_rvalid_o, data_rvalid_o}, {i == 2, i == 1 || i == 3});
      end
      n_checks++;
      if ({instr_err_o, data_err_o} !== {i == 2, 1'b0}) begin
        n_fail++; $display("FAIL rr_err[%0d] got %b want %b", i, {instr_err_o, data_err_o}, {i == 2, 1'b0});
      end
      tick();
    end
    idle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'h1234_5678}) begin
      n_fail++; $display("FAIL rr_drain got %b/%h want 10/12345678", {instr_rvalid_o, data_rvalid_o}, instr_rdata_o);
    end
    tick();
    idle();
  endtask

  task automatic test_lock();
    instr_req_i = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, IADDR}) begin
      n_fail++; $display("FAIL lock_c0 got %b/%h want 1/%h", mem_req_o, mem_addr_o, IADDR);
    end
    tick();
    for (int c = 1; c < 4; c++) begin
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
      mem_gnt_i = (c == 3);
      #1;
      n_checks++;
      if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {IADDR, 1'b0, 4'hF, 32'h0}) begin
        n_fail++; $display("FAIL lock_fields[%0d] got %h/%b/%h/%h want %h/0/f/0", c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, IADDR);
      end
      n_checks++;
      if ({instr_gnt_o, data_gnt_o} !== {c == 3, 1'b0}) begin
        n_fail++; $display("FAIL lock_gnt[%0d] got %b want %b", c, {instr_gnt_o, data_gnt_o}, {c == 3, 1'b0});
      end
      tick();
    end
    instr_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    n_checks++;
    if ({data_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {1'b1, DADDR, 1'b1, 4'h3, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL lock_data got %b/%h/%b/%h/%h want 1/%h/1/3/deadbeef", data_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, DADDR);
    end
    tick();
    idle();
    mem_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
      n_fail++; $display("FAIL lock_resp0 got %b want 10", {instr_rvalid_o, data_rvalid_o});
    end
    tick();
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
      n_fail++; $display("FAIL lock_resp1 got %b want 01", {instr_rvalid_o, data_rvalid_o});
    end
    tick();
    idle();
  endtask

  task automatic test_full();
    data_req_i = 1'b1; mem_gnt_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_gnt[%0d] got %b want 1", c, data_gnt_o); end
      tick();
    end
    #1;
    n_checks++;
    if ({mem_req_o, data_gnt_o} !== 2'b00) begin
      n_fail++; $display("FAIL full_block got %b want 00", {mem_req_o, data_gnt_o});
    end
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_o, data_gnt_o, data_rvalid_o} !== 3'b001) begin
      n_fail++; $display("FAIL full_pop got %b want 001", {mem_req_o, data_gnt_o, data_rvalid_o});
    end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if ({mem_req_o, data_gnt_o} !== 2'b11) begin
      n_fail++; $display("FAIL full_reopen got %b want 11", {mem_req_o, data_gnt_o});
    end
    tick();
    idle();
  endtask

  task automatic test_reset_outstanding();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
    #1;
    n_checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      n_fail++; $display("FAIL rst2_prio got %b want 01", {instr_gnt_o, data_gnt_o});
    end
    tick();
    n_checks++;
    if ({instr_gnt_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, IADDR}) begin
      n_fail++; $display("FAIL rst2_instr got %b/%b/%h/%h want 1/0/f/%h", instr_gnt_o, mem_we_o, mem_be_o, mem_addr_o, IADDR);
    end
    tick();
    n_checks++;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst2_full got %b want 0", mem_req_o); end
    idle();
    mem_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
      n_fail++; $display("FAIL rst2_resp0 got %b want 01", {instr_rvalid_o, data_rvalid_o});
    end
    tick();
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
      n_fail++; $display("FAIL rst2_resp1 got %b want 10", {instr_rvalid_o, data_rvalid_o});
    end
    tick();
    idle();
  endtask

  task automatic test_protocol_err();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 3'b000) begin
      n_fail++; $display("FAIL perr_same got %b want 000", {instr_rvalid_o, data_rvalid_o, protocol_err_o});
    end
    n_checks++;
    if ({instr_rdata_o, data_rdata_o} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL rdata_pass got %h/%h want cafef00d", instr_rdata_o, data_rdata_o);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL perr_sticky[%0d] got %b want 1", c, protocol_err_o); end
      tick();
    end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL perr_clear got %b want 0", protocol_err_o); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_reset_outstanding();
    test_protocol_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
